// File: rtl/axi_llc_march_bist_gen.sv
// axi_llc_march_bist_gen: March X / March C- address and data sequencer for LLC tag SRAM BIST
module axi_llc_march_bist_gen #(
  parameter int unsigned NumWays        = 8,
  parameter int unsigned IndexWidth     = 8,
  parameter int unsigned PatternWidth   = 24,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_valid_i,
  output logic                    start_ready_o,
  input  logic                    march_c_i,
  output logic                    req_o,
  output logic                    we_o,
  output logic [IndexWidth-1:0]   index_o,
  output logic [PatternWidth-1:0] pattern_o,
  input  logic                    sram_gnt_i,
  output logic                    expect_o,
  input  logic                    cmp_valid_i,
  input  logic [NumWays-1:0]      cmp_res_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    eoc_o,
  output logic [NumWays-1:0]      fail_ways_o,
  output logic [2:0]              fail_elem_o,
  output logic [15:0]             fail_cnt_o
);
  localparam int unsigned OW = $clog2(MaxOutstanding + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic march_c_q, march_c_d, op_q, op_d, eoc_q, eoc_d;
  logic [2:0] elem_q, elem_d, fail_elem_q, fail_elem_d, next_elem;
  logic [IndexWidth-1:0] index_q, index_d, end_index;
  logic [OW-1:0] outs_q, outs_d;
  logic [NumWays-1:0] fail_ways_q, fail_ways_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic first_elem, last_elem, down, next_down, we, pol, run, req, grant, rd_gnt, cmp, cmp_fail;

  function automatic logic is_down(input logic mc, input logic [2:0] e);
    return mc ? (e == 3'd3 || e == 3'd4) : e == 3'd2;
  endfunction

  // Every two-op element is (r p, w ~p) with p = 0 on odd elements and 1 on even ones;
  // element 0 is the lone w0 and the last element is the lone r0.
  assign first_elem = elem_q == 3'd0;
  assign last_elem  = elem_q == (march_c_q ? 3'd5 : 3'd3);
  assign next_elem  = elem_q + 3'd1;
  assign down       = is_down(march_c_q, elem_q);
  assign next_down  = is_down(march_c_q, next_elem);
  assign end_index  = down ? '0 : '1;
  assign we         = op_q | first_elem;
  assign pol        = op_q ? elem_q[0] : !first_elem && !elem_q[0];
  assign run        = state_q == RUN;
  assign req        = run && (we || outs_q != OW'(MaxOutstanding));
  assign grant      = req && sram_gnt_i;
  assign rd_gnt     = grant && !we;
  assign cmp        = cmp_valid_i && outs_q != '0;
  assign cmp_fail   = cmp && !(&cmp_res_i);

  always_comb begin
    state_d     = state_q;
    march_c_d   = march_c_q;
    elem_d      = elem_q;
    op_d        = op_q;
    index_d     = index_q;
    eoc_d       = eoc_q;
    outs_d      = outs_q + OW'(rd_gnt) - OW'(cmp);
    fail_ways_d = cmp_fail ? fail_ways_q | ~cmp_res_i : fail_ways_q;
    fail_cnt_d  = cmp_fail && !(&fail_cnt_q) ? fail_cnt_q + 16'd1 : fail_cnt_q;
    fail_elem_d = cmp_fail && fail_cnt_q == '0 ? elem_q : fail_elem_q;
    unique case (state_q)
      IDLE: if (start_valid_i) begin
        state_d     = RUN;
        march_c_d   = march_c_i;
        elem_d      = '0;
        op_d        = 1'b0;
        index_d     = '0;
        eoc_d       = 1'b0;
        fail_ways_d = '0;
        fail_elem_d = '0;
        fail_cnt_d  = '0;
      end
      RUN: if (grant) begin
        if (!op_q && !first_elem && !last_elem) op_d = 1'b1;
        else begin
          op_d = 1'b0;
          if (index_q == end_index) state_d = DRAIN;
          else index_d = down ? index_q - IndexWidth'(1) : index_q + IndexWidth'(1);
        end
      end
      DRAIN: if (outs_q == '0) begin
        if (last_elem) begin
          state_d = DONE;
          eoc_d   = 1'b1;
        end else begin
          state_d = RUN;
          elem_d  = next_elem;
          index_d = next_down ? '1 : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      march_c_q   <= 1'b0;
      elem_q      <= '0;
      op_q        <= 1'b0;
      index_q     <= '0;
      eoc_q       <= 1'b0;
      outs_q      <= '0;
      fail_ways_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      march_c_q   <= march_c_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      index_q     <= index_d;
      eoc_q       <= eoc_d;
      outs_q      <= outs_d;
      fail_ways_q <= fail_ways_d;
      fail_elem_q <= fail_elem_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign start_ready_o = state_q == IDLE;
  assign req_o         = req;
  assign we_o          = run && we;
  assign index_o       = index_q;
  assign expect_o      = run && pol;
  assign pattern_o     = {PatternWidth{run && pol}};
  assign busy_o        = run || state_q == DRAIN;
  assign done_o        = state_q == DONE;
  assign eoc_o         = eoc_q;
  assign fail_ways_o   = fail_ways_q;
  assign fail_elem_o   = fail_elem_q;
  assign fail_cnt_o    = fail_cnt_q;
endmodule

// File: tb/tb_axi_llc_march_bist_gen.sv
// tb_axi_llc_march_bist_gen: randomized bench for the March BIST sequencer against an element-table model
module tb_axi_llc_march_bist_gen;
  localparam int IW = 3, NW = 8, PW = 24, MO = 4, DEPTH = 1 << IW;
  logic clk_i = 0, rst_i = 1, start_valid_i = 0, march_c_i = 0, sram_gnt_i = 0, cmp_valid_i = 0;
  logic [NW-1:0] cmp_res_i = '1;
  logic start_ready_o, req_o, we_o, expect_o, busy_o, done_o, eoc_o;
  logic [IW-1:0] index_o;
  logic [PW-1:0] pattern_o;
  logic [NW-1:0] fail_ways_o;
  logic [2:0] fail_elem_o;
  logic [15:0] fail_cnt_o;
  int n_chk = 0, n_fail = 0;
  typedef struct {bit we; bit pol; int idx; int elem;} op_t;
  typedef struct {int due; logic [NW-1:0] res;} beat_t;
  op_t exp_q[$];
  beat_t pipe[$];
  int n_grants, seq_err, stall_err, done_cnt, full_viol, full_cycles, order_err, pend;
  bit start_ok, eoc_cleared;

  always #5 clk_i = ~clk_i;

  axi_llc_march_bist_gen #(.NumWays(NW), .IndexWidth(IW), .PatternWidth(PW), .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
    .march_c_i(march_c_i), .req_o(req_o), .we_o(we_o), .index_o(index_o), .pattern_o(pattern_o),
    .sram_gnt_i(sram_gnt_i), .expect_o(expect_o), .cmp_valid_i(cmp_valid_i), .cmp_res_i(cmp_res_i),
    .busy_o(busy_o), .done_o(done_o), .eoc_o(eoc_o), .fail_ways_o(fail_ways_o),
    .fail_elem_o(fail_elem_o), .fail_cnt_o(fail_cnt_o)
  );

  // One element: a first op at every address, optionally followed by a write of the opposite polarity.
  task automatic add_elem(input int e, input bit down, input bit w0, input bit p0, input bit two);
    for (int k = 0; k < DEPTH; k++) begin
      int idx = down ? DEPTH - 1 - k : k;
      exp_q.push_back('{w0, p0, idx, e});
      if (two) exp_q.push_back('{1'b1, !p0, idx, e});
    end
  endtask

  task automatic build_model(input bit mc);
    exp_q.delete();
    add_elem(0, 0, 1, 0, 0);
    add_elem(1, 0, 0, 0, 1);
    if (!mc) begin
      add_elem(2, 1, 0, 1, 1);
      add_elem(3, 0, 0, 0, 0);
    end else begin
      add_elem(2, 0, 0, 1, 1);
      add_elem(3, 1, 0, 0, 1);
      add_elem(4, 1, 0, 1, 1);
      add_elem(5, 0, 0, 0, 0);
    end
  endtask

  task automatic drive_run(input bit mc, input int lat, input bit rnd, input logic [NW-1:0] f2,
                           input logic [NW-1:0] f3, input int stop_after);
    op_t e;
    bit prev_stall = 0, f2_used = 0, f3_used = 0, g;
    logic [IW-1:0] p_idx = '0;
    logic [PW-1:0] p_pat = '0;
    logic p_we = 0;
    logic [NW-1:0] r;
    int cyc = 0, done_cyc = -1, last_elem = -1, pend_start;
    build_model(mc);
    pipe.delete();
    {n_grants, seq_err, stall_err, done_cnt, full_viol, full_cycles, order_err, pend} = '0;
    @(negedge clk_i);
    start_ok = start_ready_o;
    start_valid_i = 1;
    march_c_i = mc;
    @(negedge clk_i);
    start_valid_i = 0;
    march_c_i = 1'($urandom_range(0, 1));
    eoc_cleared = !eoc_o && busy_o;
    while (cyc < 4000) begin
      if (prev_stall && (!req_o || index_o !== p_idx || pattern_o !== p_pat || we_o !== p_we)) stall_err++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      pend_start = pend;
      if (pend == MO && req_o && !we_o) full_viol++;
      if (pend == MO && busy_o) full_cycles++;
      cmp_valid_i = 0;
      cmp_res_i = NW'($urandom);
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        cmp_valid_i = 1;
        cmp_res_i = pipe[0].res;
        pipe.delete(0);
        pend--;
      end
      g = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      sram_gnt_i = g;
      if (req_o && g) begin
        n_grants++;
        if (exp_q.size() == 0) seq_err++;
        else begin
          e = exp_q.pop_front();
          if (we_o !== e.we || index_o !== IW'(e.idx) || pattern_o !== {PW{e.pol}} || (!e.we && expect_o !== e.pol))
            seq_err++;
          if (e.elem != last_elem && pend_start != 0) order_err++;
          last_elem = e.elem;
          if (!e.we) begin
            r = '1;
            if (e.elem == 2 && !f2_used) begin r = f2; f2_used = 1; end
            else if (e.elem == 3 && !f3_used) begin r = f3; f3_used = 1; end
            pipe.push_back('{cyc + lat, r});
            pend++;
          end
        end
      end
      prev_stall = req_o && !g;
      p_idx = index_o;
      p_pat = pattern_o;
      p_we = we_o;
      if (stop_after > 0 && n_grants >= stop_after) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk_i);
      cyc++;
    end
    @(negedge clk_i);
    sram_gnt_i = 0;
    cmp_valid_i = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_chk++;
    if ({start_ready_o, req_o, we_o, busy_o, done_o, eoc_o, expect_o} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 1000000", {start_ready_o, req_o, we_o, busy_o, done_o, eoc_o, expect_o});
    end
    n_chk++;
    if (index_o !== '0 || pattern_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got idx %0h pat %0h expected 0 0", index_o, pattern_o);
    end
    n_chk++;
    if (fail_ways_o !== '0 || fail_elem_o !== '0 || fail_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_fail: got %0h %0h %0h expected 0 0 0", fail_ways_o, fail_elem_o, fail_cnt_o);
    end
    rst_i = 0;
  endtask

  task automatic test_march_x;
    drive_run(0, 2, 0, '1, '1, 0);
    n_chk++;
    if (!start_ok) begin n_fail++; $display("FAIL mx_start_ready: got 0 expected 1"); end
    n_chk++;
    if (n_grants != 6 * DEPTH) begin n_fail++; $display("FAIL mx_grants: got %0d expected %0d", n_grants, 6 * DEPTH); end
    n_chk++;
    if (seq_err != 0) begin n_fail++; $display("FAIL mx_sequence: got %0d bad ops expected 0", seq_err); end
    n_chk++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL mx_done_pulse: got %0d expected 1", done_cnt); end
    n_chk++;
    if (fail_ways_o !== '0 || fail_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL mx_no_fail: got ways %0h cnt %0d expected 0 0", fail_ways_o, fail_cnt_o);
    end
    n_chk++;
    if ({eoc_o, busy_o, start_ready_o} !== 3'b101) begin
      n_fail++;
      $display("FAIL mx_end_state: got %b expected 101", {eoc_o, busy_o, start_ready_o});
    end
  endtask

  task automatic test_march_c;
    drive_run(1, 3, 0, '1, '1, 0);
    n_chk++;
    if (!eoc_cleared) begin n_fail++; $display("FAIL mc_eoc_cleared: got 0 expected 1"); end
    n_chk++;
    if (n_grants != 10 * DEPTH) begin n_fail++; $display("FAIL mc_grants: got %0d expected %0d", n_grants, 10 * DEPTH); end
    n_chk++;
    if (seq_err != 0) begin n_fail++; $display("FAIL mc_sequence: got %0d bad ops expected 0", seq_err); end
    n_chk++;
    if (done_cnt != 1 || eoc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mc_done_eoc: got done %0d eoc %b expected 1 1", done_cnt, eoc_o);
    end
  endtask

  task automatic test_outstanding;
    for (int m = 0; m < 2; m++) begin
      drive_run(m[0], 6, 0, '1, '1, 0);
      n_chk++;
      if (full_viol != 0) begin n_fail++; $display("FAIL os_read_at_limit: got %0d expected 0", full_viol); end
      n_chk++;
      if (full_cycles == 0) begin n_fail++; $display("FAIL os_limit_reached: got %0d cycles expected >0", full_cycles); end
      n_chk++;
      if (order_err != 0) begin n_fail++; $display("FAIL os_drain_order: got %0d expected 0", order_err); end
      n_chk++;
      if (seq_err != 0 || done_cnt != 1) begin
        n_fail++;
        $display("FAIL os_sequence: got err %0d done %0d expected 0 1", seq_err, done_cnt);
      end
    end
  endtask

  task automatic test_fail_log;
    drive_run(0, 2, 0, 8'hF7, 8'hFE, 0);
    n_chk++;
    if (fail_ways_o !== 8'h09) begin n_fail++; $display("FAIL fl_ways: got %0h expected 09", fail_ways_o); end
    n_chk++;
    if (fail_elem_o !== 3'd2) begin n_fail++; $display("FAIL fl_elem: got %0d expected 2", fail_elem_o); end
    n_chk++;
    if (fail_cnt_o !== 16'd2) begin n_fail++; $display("FAIL fl_cnt: got %0d expected 2", fail_cnt_o); end
  endtask

  task automatic test_gnt_stall;
    drive_run(1, 4, 1, '1, '1, 0);
    n_chk++;
    if (stall_err != 0) begin n_fail++; $display("FAIL gs_stable: got %0d changes expected 0", stall_err); end
    n_chk++;
    if (seq_err != 0 || n_grants != 10 * DEPTH) begin
      n_fail++;
      $display("FAIL gs_sequence: got err %0d grants %0d expected 0 %0d", seq_err, n_grants, 10 * DEPTH);
    end
    n_chk++;
    if (order_err != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL gs_done: got order %0d done %0d expected 0 1", order_err, done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    drive_run(0, 6, 0, '1, '1, DEPTH + 4);
    rst_i = 1;
    @(negedge clk_i);
    n_chk++;
    if ({start_ready_o, busy_o, req_o, done_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rm_idle: got %b expected 1000", {start_ready_o, busy_o, req_o, done_o});
    end
    rst_i = 0;
    for (int k = 0; k < 4; k++) begin
      cmp_valid_i = 1;
      cmp_res_i = '0;
      @(negedge clk_i);
      if (done_o) dones++;
    end
    cmp_valid_i = 0;
    cmp_res_i = '1;
    n_chk++;
    if (fail_ways_o !== '0 || fail_cnt_o !== '0 || dones != 0) begin
      n_fail++;
      $display("FAIL rm_late_cmp: got ways %0h cnt %0d done %0d expected 0 0 0", fail_ways_o, fail_cnt_o, dones);
    end
    drive_run(0, 2, 1, '1, '1, 0);
    n_chk++;
    if (fail_cnt_o !== '0 || n_grants != 6 * DEPTH || seq_err != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL rm_clean_run: got cnt %0d grants %0d err %0d done %0d expected 0 %0d 0 1",
               fail_cnt_o, n_grants, seq_err, done_cnt, 6 * DEPTH);
    end
  endtask

  initial begin
    test_reset;
    test_march_x;
    test_march_c;
    test_outstanding;
    test_fail_log;
    test_gnt_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
